// File: rtl/half_period_meter.sv
// Half-period meter: times the gap between edges of an asynchronous square wave in
// synth_clk cycles, qualifying results with a consecutive-match filter and a silence timeout.
module half_period_meter #(
    parameter int HP_W    = 7,
    parameter int MATCH_N = 2,
    parameter int TIMEOUT = 255
) (
    input  logic            synth_clk,
    input  logic            rst_n,
    input  logic            audio_in,
    input  logic            enable,
    output logic [HP_W-1:0] hp_out,
    output logic            hp_valid,
    output logic            tone_lost,
    output logic            over_range
);

    localparam logic [HP_W-1:0] CNT_MAX   = '1;
    localparam logic [HP_W-1:0] CNT_ONE   = {{(HP_W-1){1'b0}}, 1'b1};
    localparam logic [8:0]      SIL_MAX   = 9'(TIMEOUT);
    localparam logic [2:0]      MATCH_TGT = 3'(MATCH_N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            s1, s2, s3;
    logic            edge_seen;
    logic [HP_W-1:0] cnt;
    logic            ovf;
    logic [8:0]      sil;
    logic            timeout;
    logic [HP_W-1:0] cand, cand_nxt;
    logic [2:0]      mcnt, mcnt_nxt;
    logic [2:0]      cand_mcnt;
    logic            cand_hit;
    logic [HP_W-1:0] hp_nxt;
    logic            valid_nxt;
    logic            lost_nxt;
    logic            ovr_nxt;

    always_ff @(posedge synth_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else if (!enable) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= audio_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_seen = s2 ^ s3;

    // cnt holds the number of cycles since the last edge, so its value in an edge cycle is the interval
    always_ff @(posedge synth_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (!enable) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (edge_seen) begin
            cnt <= CNT_ONE;
            ovf <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            ovf <= 1'b1;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge synth_clk or negedge rst_n) begin
        if (!rst_n) begin
            sil <= '0;
        end else if (!enable || edge_seen) begin
            sil <= '0;
        end else if (sil != SIL_MAX) begin
            sil <= sil + 9'd1;
        end
    end

    assign timeout   = (sil == SIL_MAX) && !edge_seen;
    assign cand_hit  = (cnt == cand) && (mcnt != 3'd0);
    assign cand_mcnt = cand_hit ? (mcnt + 3'd1) : 3'd1;

    always_ff @(posedge synth_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cand       <= '0;
            mcnt       <= '0;
            hp_out     <= '0;
            hp_valid   <= 1'b0;
            tone_lost  <= 1'b0;
            over_range <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            cand       <= '0;
            mcnt       <= '0;
            hp_out     <= '0;
            hp_valid   <= 1'b0;
            tone_lost  <= 1'b0;
            over_range <= 1'b0;
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            mcnt       <= mcnt_nxt;
            hp_out     <= hp_nxt;
            hp_valid   <= valid_nxt;
            tone_lost  <= lost_nxt;
            over_range <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        mcnt_nxt  = mcnt;
        hp_nxt    = hp_out;
        valid_nxt = hp_valid;
        lost_nxt  = 1'b0;
        ovr_nxt   = over_range;
        case (state)
            IDLE: begin
                // the interval ending at this edge started at an unknown time
                if (edge_seen) begin
                    state_nxt = ACQ;
                    cand_nxt  = '0;
                    mcnt_nxt  = '0;
                end
            end
            ACQ: begin
                if (edge_seen) begin
                    if (ovf) begin
                        ovr_nxt  = 1'b1;
                        mcnt_nxt = '0;
                    end else begin
                        cand_nxt = cnt;
                        mcnt_nxt = cand_mcnt;
                        if (cand_mcnt == MATCH_TGT) begin
                            hp_nxt    = cnt;
                            valid_nxt = 1'b1;
                            mcnt_nxt  = '0;
                            state_nxt = LOCKED;
                        end
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    mcnt_nxt  = '0;
                end
            end
            LOCKED: begin
                if (edge_seen) begin
                    if (ovf) begin
                        ovr_nxt  = 1'b1;
                        mcnt_nxt = '0;
                    end else if (cnt == hp_out) begin
                        mcnt_nxt = '0;
                    end else begin
                        // a new pitch must prove itself before it replaces the held value
                        cand_nxt = cnt;
                        mcnt_nxt = cand_mcnt;
                        if (cand_mcnt == MATCH_TGT) begin
                            hp_nxt   = cnt;
                            mcnt_nxt = '0;
                        end
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    mcnt_nxt  = '0;
                    hp_nxt    = '0;
                    valid_nxt = 1'b0;
                    lost_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_half_period_meter.sv
// Bench for half_period_meter: directed tone scenarios plus random tones, compared every
// cycle against an edge-timestamp reference model.
module tb_half_period_meter;

    localparam int HP_W    = 7;
    localparam int MATCH_N = 2;
    localparam int TIMEOUT = 255;
    localparam int MAX_M   = (1 << HP_W) - 1;

    logic            synth_clk = 1'b0;
    logic            rst_n     = 1'b0;
    logic            audio_in  = 1'b0;
    logic            enable    = 1'b1;
    logic [HP_W-1:0] hp_out;
    logic            hp_valid;
    logic            tone_lost;
    logic            over_range;

    int errors = 0;
    int checks = 0;

    half_period_meter #(.HP_W(HP_W), .MATCH_N(MATCH_N), .TIMEOUT(TIMEOUT)) dut (
        .synth_clk (synth_clk),
        .rst_n     (rst_n),
        .audio_in  (audio_in),
        .enable    (enable),
        .hp_out    (hp_out),
        .hp_valid  (hp_valid),
        .tone_lost (tone_lost),
        .over_range(over_range)
    );

    always #5 synth_clk = ~synth_clk;

    // reference model: intervals are differences of edge timestamps
    int   cyc = 0;
    logic hist[$];
    bit   tracking;
    bit   locked;
    int   last_edge;
    int   cand;
    int   mcnt;
    int   exp_hp;
    bit   exp_valid;
    bit   exp_lost;
    bit   exp_ovr;
    int   lost_pulses;

    task automatic model_clear();
        hist = '{1'b0, 1'b0, 1'b0, 1'b0};
        tracking  = 1'b0;
        locked    = 1'b0;
        last_edge = 0;
        cand      = 0;
        mcnt      = 0;
        exp_hp    = 0;
        exp_valid = 1'b0;
        exp_lost  = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic model_cycle();
        int  m;
        bit  e;
        hist.push_front(audio_in);
        void'(hist.pop_back());
        e = (hist[2] != hist[3]);
        exp_lost = 1'b0;
        if (e) begin
            m = cyc - last_edge;
            if (!tracking && !locked) begin
                tracking = 1'b1;
                mcnt = 0;
            end else if (m > MAX_M) begin
                exp_ovr = 1'b1;
                mcnt = 0;
            end else if (locked && m == exp_hp) begin
                mcnt = 0;
            end else begin
                if (mcnt > 0 && m == cand) mcnt++;
                else begin
                    cand = m;
                    mcnt = 1;
                end
                if (mcnt == MATCH_N) begin
                    exp_hp    = m;
                    exp_valid = 1'b1;
                    locked    = 1'b1;
                    tracking  = 1'b0;
                    mcnt      = 0;
                end
            end
            last_edge = cyc;
        end else if ((tracking || locked) && (cyc - last_edge - 1) >= TIMEOUT) begin
            if (locked) begin
                exp_lost  = 1'b1;
                exp_hp    = 0;
                exp_valid = 1'b0;
            end
            locked   = 1'b0;
            tracking = 1'b0;
            mcnt     = 0;
        end
    endtask

    task automatic compare(input string tag);
        checks++;
        assert (hp_out === HP_W'(exp_hp)) else begin
            errors++;
            $error("FAIL %s hp_out cyc=%0d: got %0d expected %0d", tag, cyc, hp_out, exp_hp);
        end
        checks++;
        assert (hp_valid === exp_valid) else begin
            errors++;
            $error("FAIL %s hp_valid cyc=%0d: got %0b expected %0b", tag, cyc, hp_valid, exp_valid);
        end
        checks++;
        assert (tone_lost === exp_lost) else begin
            errors++;
            $error("FAIL %s tone_lost cyc=%0d: got %0b expected %0b", tag, cyc, tone_lost, exp_lost);
        end
        checks++;
        assert (over_range === exp_ovr) else begin
            errors++;
            $error("FAIL %s over_range cyc=%0d: got %0b expected %0b", tag, cyc, over_range, exp_ovr);
        end
    endtask

    string phase = "reset";

    task automatic step();
        @(posedge synth_clk);
        cyc++;
        if (!rst_n || !enable) model_clear();
        else model_cycle();
        #1;
        if (tone_lost === 1'b1) lost_pulses++;
        compare(phase);
    endtask

    task automatic tone(input int hp, input int n);
        for (int i = 0; i < n; i++) begin
            audio_in = ~audio_in;
            repeat (hp) step();
        end
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        model_clear();
        #1;
        phase = tag;
        compare(tag);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int seq_glitch[7];
        model_clear();
        lost_pulses = 0;

        // reset state
        #2;
        compare("reset_async");
        step();
        step();
        rst_n = 1'b1;
        step();

        // hp=5 tone, lock then hold for 100 half-periods
        phase = "tone5";
        tone(5, 103);
        checks++;
        assert (hp_out === 7'd5 && hp_valid === 1'b1) else begin
            errors++;
            $error("FAIL tone5_locked: got hp=%0d valid=%0b expected 5/1", hp_out, hp_valid);
        end

        // switch to 9
        phase = "switch9";
        tone(9, 4);
        checks++;
        assert (hp_out === 7'd9) else begin
            errors++;
            $error("FAIL switch9: got %0d expected 9", hp_out);
        end

        // glitches while locked at 5
        phase = "glitch";
        seq_glitch = '{5, 5, 5, 3, 2, 5, 5};
        foreach (seq_glitch[i]) tone(seq_glitch[i], 1);
        tone(5, 2);
        checks++;
        assert (hp_out === 7'd5) else begin
            errors++;
            $error("FAIL glitch_hold: got %0d expected 5", hp_out);
        end

        // lock at 20, then silence
        phase = "timeout";
        tone(20, 5);
        lost_pulses = 0;
        repeat (TIMEOUT + 20) step();
        checks++;
        assert (lost_pulses === 1) else begin
            errors++;
            $error("FAIL timeout_pulses: got %0d expected 1", lost_pulses);
        end
        phase = "reacq";
        tone(12, 6);

        // over-range interval, then enable clear
        phase = "ovr";
        tone(200, 1);
        tone(12, 3);
        checks++;
        assert (over_range === 1'b1 && hp_out === 7'd12) else begin
            errors++;
            $error("FAIL ovr_sticky: got ovr=%0b hp=%0d expected 1/12", over_range, hp_out);
        end
        enable = 1'b0;
        phase = "enable_clr";
        step();
        enable = 1'b1;
        step();

        // async reset mid-ACQ and mid-LOCKED
        phase = "acq";
        tone(6, 2);
        async_reset("rst_acq");
        phase = "lock";
        tone(7, 6);
        async_reset("rst_locked");
        step();

        // random tones with glitches, overflows and silences
        phase = "random";
        for (int seg = 0; seg < 40; seg++) begin
            tone($urandom_range(1, 40), $urandom_range(2, 10));
            if ($urandom_range(0, 3) == 0) tone($urandom_range(1, 150), 1);
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(200, 300)) step();
            if ($urandom_range(0, 15) == 0) begin
                enable = 1'b0;
                step();
                enable = 1'b1;
            end
        end
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
